// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and constants for the note sequencer.
//   seq_state_t      - sequencer FSM states
//   NOTE_LEN_W       - width of a note duration (timer units)
//   CNT_W            - width of the hit/miss/streak counters
//   WAIT_HIGH_LIMIT  - cycles allowed for the timer to raise its output
//   NOTE_LENGTHS     - default song, one duration per note
//   sat_inc()        - saturating increment for the score counters
package note_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_WAIT_HIGH,
        S_ACTIVE,
        S_NEXT,
        S_DONE
    } seq_state_t;

    localparam int NOTE_LEN_W      = 32;
    localparam int CNT_W           = 8;
    localparam int WAIT_HIGH_LIMIT = 2;
    localparam int ROM_DEPTH       = 16;

    // Default song. A four-note song plays the first four equal-length
    // entries; the longer entry and the two zero-length entries that follow
    // give single-cycle and wide hit windows in a full-length song.
    localparam logic [NOTE_LEN_W-1:0] NOTE_LENGTHS [0:ROM_DEPTH-1] = '{
        32'd3, 32'd3, 32'd3, 32'd3,
        32'd10, 32'd0, 32'd0, 32'd4,
        32'd2, 32'd2, 32'd2, 32'd2,
        32'd2, 32'd2, 32'd2, 32'd2
    };

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/note_rom.sv
// note_rom: song table with a one-cycle registered read.
// Ports:
//   clock  in             system clock, rising edge
//   addr   in  IDX_W      note index
//   data   out NOTE_LEN_W duration of the note at addr, one cycle later
// Addresses beyond the table read as zero.
module note_rom
    import note_seq_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic                  clock,
    input  logic [IDX_W-1:0]      addr,
    output logic [NOTE_LEN_W-1:0] data
);

    logic [NOTE_LEN_W-1:0] data_q;
    logic [NOTE_LEN_W-1:0] data_d;

    always_comb begin
        data_d = '0;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            if (int'(addr) == i) begin
                data_d = NOTE_LENGTHS[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: song-playback controller for one game lane. Walks the
// note table, starts the downstream timer once per note, opens a hit
// window while the timer output is high and scores button presses.
// Ports:
//   clock, reset           clock and synchronous active-high reset
//   go, abort              start song (IDLE/DONE only) / return to IDLE
//   button                 synchronised, debounced player button
//   timer_out              output of the downstream timer
//   timer_start            one-cycle start pulse to the timer
//   timer_length [31:0]    duration of the current note
//   note_idx [IDX_W-1:0]   index of the current note
//   note_active            hit window open (combinational)
//   hits, misses [7:0]     saturating score counters
//   done, error            song finished / timer did not respond
// Optional feature, enabled by defining NOTE_SEQ_STREAK_EN:
//   streak, best_streak [7:0]  current and best run of consecutive hits
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int NUM_NOTES = 16,
    parameter int IDX_W     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  abort,
    input  logic                  button,
    input  logic                  timer_out,
    output logic                  timer_start,
    output logic [NOTE_LEN_W-1:0] timer_length,
    output logic [IDX_W-1:0]      note_idx,
    output logic                  note_active,
    output logic [CNT_W-1:0]      hits,
    output logic [CNT_W-1:0]      misses,
    output logic                  done,
    output logic                  error
`ifdef NOTE_SEQ_STREAK_EN
    ,
    output logic [CNT_W-1:0]      streak,
    output logic [CNT_W-1:0]      best_streak
`endif
);

    localparam int WAIT_W = 2;

    seq_state_t            state_q, state_d;
    logic [IDX_W-1:0]      note_idx_q, note_idx_d;
    logic                  timer_start_q, timer_start_d;
    logic [NOTE_LEN_W-1:0] timer_length_q, timer_length_d;
    logic [CNT_W-1:0]      hits_q, hits_d;
    logic [CNT_W-1:0]      misses_q, misses_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  button_q, button_d;
    logic                  hit_seen_q, hit_seen_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;

    logic [NOTE_LEN_W-1:0] rom_data;
    logic                  window_open;
    logic                  press_edge;
    logic                  hit_now;

`ifdef NOTE_SEQ_STREAK_EN
    logic [CNT_W-1:0]      streak_q, streak_d;
    logic [CNT_W-1:0]      best_q, best_d;
    logic [CNT_W-1:0]      streak_inc;
`endif

    // The ROM is addressed with the next-state index so that its registered
    // output already holds the current note's length while in LOAD; the
    // length register then updates on the edge into ARM, together with the
    // start pulse, and the timer sees both in the same cycle.
    note_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .clock (clock),
        .addr  (note_idx_d),
        .data  (rom_data)
    );

    assign window_open = ((state_q == S_WAIT_HIGH) || (state_q == S_ACTIVE)) && timer_out;
    assign press_edge  = button && !button_q;
    // Only the first qualifying edge of a note scores.
    assign hit_now     = window_open && press_edge && !hit_seen_q;

`ifdef NOTE_SEQ_STREAK_EN
    assign streak_inc  = sat_inc(streak_q);
`endif

    always_comb begin
        state_d        = state_q;
        note_idx_d     = note_idx_q;
        timer_start_d  = 1'b0;
        timer_length_d = timer_length_q;
        hits_d         = hits_q;
        misses_d       = misses_q;
        done_d         = done_q;
        error_d        = error_q;
        button_d       = button;
        hit_seen_d     = hit_seen_q;
        wait_cnt_d     = wait_cnt_q;
`ifdef NOTE_SEQ_STREAK_EN
        streak_d       = streak_q;
        best_d         = best_q;
`endif

        if (hit_now) begin
            hits_d     = sat_inc(hits_q);
            hit_seen_d = 1'b1;
`ifdef NOTE_SEQ_STREAK_EN
            streak_d   = streak_inc;
            if (streak_inc > best_q) begin
                best_d = streak_inc;
            end
`endif
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    hits_d     = '0;
                    misses_d   = '0;
                    note_idx_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    hit_seen_d = 1'b0;
`ifdef NOTE_SEQ_STREAK_EN
                    streak_d   = '0;
                    best_d     = '0;
`endif
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                timer_start_d  = 1'b1;
                timer_length_d = rom_data;
                hit_seen_d     = 1'b0;
                wait_cnt_d     = '0;
                state_d        = S_ARM;
            end
            S_ARM: begin
                state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (timer_out) begin
                    state_d = S_ACTIVE;
                end else if (wait_cnt_q == WAIT_W'(WAIT_HIGH_LIMIT - 1)) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!timer_out) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!hit_seen_q) begin
                    misses_d = sat_inc(misses_q);
`ifdef NOTE_SEQ_STREAK_EN
                    streak_d = '0;
`endif
                end
                if (note_idx_q == IDX_W'(NUM_NOTES - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    note_idx_d = note_idx_q + 1'b1;
                    state_d    = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over go and over any scoring in the same cycle.
        if (abort) begin
            state_d       = S_IDLE;
            note_idx_d    = note_idx_q;
            timer_start_d = 1'b0;
            hits_d        = hits_q;
            misses_d      = misses_q;
            done_d        = 1'b0;
            error_d       = 1'b0;
            hit_seen_d    = hit_seen_q;
`ifdef NOTE_SEQ_STREAK_EN
            streak_d      = streak_q;
            best_d        = best_q;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            note_idx_q     <= '0;
            timer_start_q  <= 1'b0;
            timer_length_q <= '0;
            hits_q         <= '0;
            misses_q       <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            button_q       <= 1'b0;
            hit_seen_q     <= 1'b0;
            wait_cnt_q     <= '0;
`ifdef NOTE_SEQ_STREAK_EN
            streak_q       <= '0;
            best_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            note_idx_q     <= note_idx_d;
            timer_start_q  <= timer_start_d;
            timer_length_q <= timer_length_d;
            hits_q         <= hits_d;
            misses_q       <= misses_d;
            done_q         <= done_d;
            error_q        <= error_d;
            button_q       <= button_d;
            hit_seen_q     <= hit_seen_d;
            wait_cnt_q     <= wait_cnt_d;
`ifdef NOTE_SEQ_STREAK_EN
            streak_q       <= streak_d;
            best_q         <= best_d;
`endif
        end
    end

    assign timer_start  = timer_start_q;
    assign timer_length = timer_length_q;
    assign note_idx     = note_idx_q;
    assign note_active  = window_open;
    assign hits         = hits_q;
    assign misses       = misses_q;
    assign done         = done_q;
    assign error        = error_q;
`ifdef NOTE_SEQ_STREAK_EN
    assign streak       = streak_q;
    assign best_streak  = best_q;
`endif

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed bench for note_sequencer. Two instances share
// clock and reset: a four-note song and a full sixteen-note song, each
// driving a cycle-accurate timer model (1 unit = 1 cycle; a length-L note
// keeps the timer output high for L+1 cycles, a zero-length note for one).
// Expected values are pushed to a scoreboard queue when stimulus is applied
// and popped when the corresponding DUT output is observed.
// Streak ports are connected and checked when NOTE_SEQ_STREAK_EN is defined.
module tb_note_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic        go4, abort4, btn4, tout4, tstart4, act4, done4, err4;
    logic [31:0] tlen4;
    logic [1:0]  idx4;
    logic [7:0]  hits4, miss4;

    logic        go16, abort16, btn16, tout16, tstart16, act16, done16, err16;
    logic [31:0] tlen16;
    logic [3:0]  idx16;
    logic [7:0]  hits16, miss16;

`ifdef NOTE_SEQ_STREAK_EN
    logic [7:0]  streak4, best4, streak16, best16;
`endif

    note_sequencer #(.NUM_NOTES(4), .IDX_W(2)) u_dut4 (
        .clock(clock), .reset(reset), .go(go4), .abort(abort4), .button(btn4),
        .timer_out(tout4), .timer_start(tstart4), .timer_length(tlen4),
        .note_idx(idx4), .note_active(act4), .hits(hits4), .misses(miss4),
        .done(done4), .error(err4)
`ifdef NOTE_SEQ_STREAK_EN
        , .streak(streak4), .best_streak(best4)
`endif
    );

    note_sequencer #(.NUM_NOTES(16), .IDX_W(4)) u_dut16 (
        .clock(clock), .reset(reset), .go(go16), .abort(abort16), .button(btn16),
        .timer_out(tout16), .timer_start(tstart16), .timer_length(tlen16),
        .note_idx(idx16), .note_active(act16), .hits(hits16), .misses(miss16),
        .done(done16), .error(err16)
`ifdef NOTE_SEQ_STREAK_EN
        , .streak(streak16), .best_streak(best16)
`endif
    );

    // Timer models
    logic        t4_out, t16_out, dead16;
    logic [31:0] t4_cnt, t16_cnt;

    always @(posedge clock) begin
        if (reset) begin
            t4_out <= 1'b0;
            t4_cnt <= '0;
        end else if (tstart4) begin
            t4_out <= 1'b1;
            t4_cnt <= tlen4;
        end else if (t4_out) begin
            if (t4_cnt == 0) t4_out <= 1'b0;
            else             t4_cnt <= t4_cnt - 1;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            t16_out <= 1'b0;
            t16_cnt <= '0;
        end else if (tstart16 && !dead16) begin
            t16_out <= 1'b1;
            t16_cnt <= tlen16;
        end else if (t16_out) begin
            if (t16_cnt == 0) t16_out <= 1'b0;
            else              t16_cnt <= t16_cnt - 1;
        end
    end

    assign tout4  = t4_out;
    assign tout16 = t16_out;

    // Cycle counter and start-pulse monitors
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int starts4[$];
    int n_start16 = 0;
    always @(negedge clock) begin
        if (tstart4)  starts4.push_back(cyc);
        if (tstart16) n_start16 = n_start16 + 1;
    end

    // Scoreboard
    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic check_next(input logic [31:0] obs);
        sb_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $error("FAIL scoreboard: observed %0d with nothing expected", obs);
            return;
        end
        e = exp_q.pop_front();
        check(e.tag, obs, e.val);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int go_cyc;
        int n0;

        reset = 1'b1;
        go4 = 1'b0;  abort4 = 1'b0;  btn4 = 1'b0;
        go16 = 1'b0; abort16 = 1'b0; btn16 = 1'b0;
        dead16 = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_tstart", tstart16, 0);
        check("rst_tlen",   tlen16,   0);
        check("rst_idx",    idx16,    0);
        check("rst_active", act16,    0);
        check("rst_hits",   hits16,   0);
        check("rst_misses", miss16,   0);
        check("rst_done",   done16,   0);
        check("rst_error",  err16,    0);
        reset = 1'b0;
        @(negedge clock);

        // Four-note song {3,3,3,3}, one press per window
        go_cyc = cyc;
        for (int i = 0; i < 4; i++) expect_val($sformatf("start%0d_cyc", i), go_cyc + 2 + 8 * i);
        expect_val("n_starts4", 4);
        expect_val("song4_hits", 4);
        expect_val("song4_misses", 0);
        expect_val("song4_done", 1);
        expect_val("song4_error", 0);
`ifdef NOTE_SEQ_STREAK_EN
        expect_val("song4_streak", 4);
        expect_val("song4_best", 4);
`endif
        go4 = 1'b1;
        @(negedge clock);
        go4 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 30 && !act4; k++) @(negedge clock);
            btn4 = 1'b1;
            @(negedge clock);
            btn4 = 1'b0;
            for (int k = 0; k < 30 && act4; k++) @(negedge clock);
        end
        for (int k = 0; k < 20 && !done4; k++) @(negedge clock);
        for (int i = 0; i < 4; i++) check_next((i < starts4.size()) ? starts4[i] : -1);
        check_next(starts4.size());
        check_next(hits4);
        check_next(miss4);
        check_next(done4);
        check_next(err4);
`ifdef NOTE_SEQ_STREAK_EN
        check_next(streak4);
        check_next(best4);
`endif

        // Sixteen notes, no presses
        expect_val("idle_hits", 0);
        expect_val("idle_misses", 16);
        expect_val("idle_done", 1);
        expect_val("idle_error", 0);
`ifdef NOTE_SEQ_STREAK_EN
        expect_val("idle_streak", 0);
        expect_val("idle_best", 0);
`endif
        go16 = 1'b1;
        @(negedge clock);
        go16 = 1'b0;
        for (int k = 0; k < 400 && !done16; k++) @(negedge clock);
        check_next(hits16);
        check_next(miss16);
        check_next(done16);
        check_next(err16);
`ifdef NOTE_SEQ_STREAK_EN
        check_next(streak16);
        check_next(best16);
`endif

        // Held button on note 0, triple press on note 4 (length 10),
        // in-window press on note 5 (length 0), late press on note 6 (length 0)
        expect_val("n4_hits", 1);
        expect_val("n4_misses", 4);
        expect_val("zero_hit_hits", 2);
        expect_val("zero_hit_misses", 4);
        expect_val("zero_late_hits", 2);
        expect_val("zero_late_misses", 5);
`ifdef NOTE_SEQ_STREAK_EN
        expect_val("zero_late_streak", 0);
        expect_val("zero_late_best", 2);
`endif
        go16 = 1'b1;
        btn16 = 1'b1;
        @(negedge clock);
        go16 = 1'b0;
        for (int k = 0; k < 40 && !act16; k++) @(negedge clock);
        for (int k = 0; k < 40 && act16; k++) @(negedge clock);
        btn16 = 1'b0;
        for (int k = 0; k < 200 && !(idx16 == 4 && act16); k++) @(negedge clock);
        for (int p = 0; p < 3; p++) begin
            btn16 = 1'b1;
            @(negedge clock);
            btn16 = 1'b0;
            @(negedge clock);
        end
        for (int k = 0; k < 40 && idx16 != 5; k++) @(negedge clock);
        check_next(hits16);
        check_next(miss16);
        for (int k = 0; k < 10 && !act16; k++) @(negedge clock);
        btn16 = 1'b1;
        @(negedge clock);
        btn16 = 1'b0;
        for (int k = 0; k < 20 && idx16 != 6; k++) @(negedge clock);
        check_next(hits16);
        check_next(miss16);
        for (int k = 0; k < 10 && !tstart16; k++) @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        btn16 = 1'b1;
        @(negedge clock);
        btn16 = 1'b0;
        for (int k = 0; k < 20 && idx16 != 7; k++) @(negedge clock);
        check_next(hits16);
        check_next(miss16);
`ifdef NOTE_SEQ_STREAK_EN
        check_next(streak16);
        check_next(best16);
`endif

        // Abort: back to IDLE, scores kept, no further starts
        expect_val("abort_done", 0);
        expect_val("abort_hits", 2);
        expect_val("abort_misses", 5);
        expect_val("abort_starts", 0);
        abort16 = 1'b1;
        @(negedge clock);
        abort16 = 1'b0;
        n0 = n_start16;
        check_next(done16);
        check_next(hits16);
        check_next(miss16);
        repeat (20) @(negedge clock);
        check_next(n_start16 - n0);

        // Timer never responds
        expect_val("wh1_error", 0);
        expect_val("wh2_error", 0);
        expect_val("timeout_error", 1);
        expect_val("timeout_done", 1);
        expect_val("restart_error", 0);
        expect_val("restart_done", 0);
        expect_val("restart_idx", 0);
        expect_val("restart_hits", 0);
        expect_val("restart_window", 1);
        dead16 = 1'b1;
        go16 = 1'b1;
        @(negedge clock);
        go16 = 1'b0;
        for (int k = 0; k < 10 && !tstart16; k++) @(negedge clock);
        @(negedge clock);
        check_next(err16);
        @(negedge clock);
        check_next(err16);
        @(negedge clock);
        check_next(err16);
        check_next(done16);
        dead16 = 1'b0;
        go16 = 1'b1;
        @(negedge clock);
        go16 = 1'b0;
        check_next(err16);
        check_next(done16);
        check_next(idx16);
        check_next(hits16);
        for (int k = 0; k < 10 && !act16; k++) @(negedge clock);
        check_next(act16 && (idx16 == 0));

        // Reset in the middle of note 5
        expect_val("mid_rst_tstart", 0);
        expect_val("mid_rst_tlen", 0);
        expect_val("mid_rst_idx", 0);
        expect_val("mid_rst_active", 0);
        expect_val("mid_rst_hits", 0);
        expect_val("mid_rst_misses", 0);
        expect_val("mid_rst_done", 0);
        expect_val("mid_rst_error", 0);
        expect_val("mid_rst_starts", 0);
        for (int k = 0; k < 200 && idx16 != 5; k++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_next(tstart16);
        check_next(tlen16);
        check_next(idx16);
        check_next(act16);
        check_next(hits16);
        check_next(miss16);
        check_next(done16);
        check_next(err16);
`ifdef NOTE_SEQ_STREAK_EN
        check("mid_rst_streak", streak16, 0);
        check("mid_rst_best", best16, 0);
`endif
        reset = 1'b0;
        n0 = n_start16;
        repeat (30) @(negedge clock);
        check_next(n_start16 - n0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Song-playback controller that sits directly upstream of `timer`: it walks a fixed table of note durations, issues one `timer_start` pulse plus `timer_length` per note, watches `timer_out` to bound each note's hit window, and scores player button presses as hits or misses. One instance per game lane. Its outputs drive the score display and the end-of-song logic.

## Interface
Parameters:
- `NUM_NOTES`, 16: notes per song; must be ≥1.
- `IDX_W`, 4: note index width; must equal clog2(`NUM_NOTES`), minimum 1.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- `go`  in  1  start song; honoured only in IDLE or DONE.
- `abort`  in  1  return to IDLE on the next edge, from any state.
- `button`  in  1  player button, already synchronised and debounced (level).
- `timer_out`  in  1  `out` of the downstream timer.
- `timer_start`  out  1  one-cycle pulse to the timer.
- `timer_length`  out  32  note duration, timer units; stable from ARM until the next ARM.
- `note_idx`  out  IDX_W  index of the current note.
- `note_active`  out  1  hit window open.
- `hits`  out  8  saturating hit count.
- `misses`  out  8  saturating miss count.
- `done`  out  1  song finished; held until `go` or `abort`.
- `error`  out  1  timer failed to respond; held until `go` or `abort`.

## Operation
- Reset: state IDLE. All outputs 0, including `timer_length`. The edge register `button_q` is 0.
- States: IDLE, LOAD, ARM, WAIT_HIGH, ACTIVE, NEXT, DONE.
- IDLE/DONE with `go`=1: clear `hits`, `misses`, `note_idx`, `done`, `error`, then go to LOAD.
- LOAD: present `note_idx` to the ROM, which has a 1-cycle registered read. Go to ARM.
- ARM:
  - Assert `timer_start`=1 for this cycle only.
  - Latch the ROM data into `timer_length`.
  - Go to WAIT_HIGH.
- WAIT_HIGH:
  - `timer_out`=1: go to ACTIVE.
  - Still 0 on the 2nd WAIT_HIGH cycle: set `error`=1 and `done`=1, go to DONE.
- ACTIVE: `timer_out`=0 goes to NEXT.
- Hit window:
  - `note_active` = (state is WAIT_HIGH or ACTIVE) && `timer_out`.
  - A rising edge (`button` && !`button_q`) while `note_active` records a hit, at most one per note.
  - Further presses within the same note are ignored.
- Edge detection: `button_q` updates every cycle in every state. A button held from before the window does not produce a hit.
- NEXT:
  - No hit recorded for this note: `misses`+1.
  - A hit increments `hits` in the cycle of the edge.
  - `note_idx`==NUM_NOTES-1: set `done`=1 and go to DONE. Otherwise `note_idx`+1 and go to LOAD.
- Counters saturate at 255; no wrap.
- Zero-length note: the timer holds `out` high for exactly one cycle. That gives a one-cycle window in WAIT_HIGH, which is legal.
- Priority: `reset` > `abort` > `go` > normal transitions.
- `abort` clears `done`/`error` and leaves `hits`/`misses` holding their values.

## Timing
- `go` sampled at edge e: LOAD at e+1, ARM (`timer_start`=1) at e+2, WAIT_HIGH at e+3.
- A compliant timer raises `timer_out` in the first WAIT_HIGH cycle.
- Note-to-note overhead: NEXT + LOAD + ARM = 3 cycles, plus 1 WAIT_HIGH cycle.
- `hits` updates on the edge after the qualifying press cycle.
- `misses` updates on the edge leaving NEXT.
- `done` rises on the edge leaving NEXT for the last note.
- All outputs are registered except `note_active`, which is combinational from state and `timer_out`.

## Configuration
- `NOTE_SEQ_STREAK_EN` defined:
  - Adds outputs `streak` [7:0] and `best_streak` [7:0], both reset to 0.
  - `streak` +1 per hit and clears to 0 on a miss.
  - `best_streak` = max seen so far.
  - Both saturate at 255 and clear on `go`.
- Undefined: neither port exists and there is no streak logic; all other behaviour is identical.

## Structure
- Package `note_seq_pkg`:
  - state enum `seq_state_t`
  - `NOTE_LEN_W`=32
  - `CNT_W`=8
  - `WAIT_HIGH_LIMIT`=2
  - default song array `NOTE_LENGTHS[0:15]`
- Sub-module `note_rom`: holds `NOTE_LENGTHS` and performs the registered read (addr → data, 1 cycle).

## Test plan
Bench uses a cycle-accurate timer model (1 unit = 1 cycle).
- Reset mid-song at note 5 → IDLE next edge; all outputs 0; no `timer_start` afterwards.
- Lengths {3,3,3,3} (NUM_NOTES=4), one press per window → `hits`=4, `misses`=0, `done`=1; `timer_start` seen exactly 4 times, spaced per overhead.
- No presses over 16 notes → `misses`=16, `hits`=0. With streak enabled, `streak`=0 and `best_streak`=0.
- Button held high across a window, then 3 presses in one window of length 10 → held: miss; presses: exactly 1 hit.
- Zero-length note, press edge in the single window cycle → hit. Press one cycle later → miss.
- Timer model never raises `out` → `error`=1 and `done`=1 at the 2nd WAIT_HIGH cycle. A subsequent `go` clears both and restarts at `note_idx`=0.
